// File: rtl/cpu_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_host_ctrl
// Description : Host initiator that preloads CPU data memory, runs the CPU
//               req/done handshake with a timeout, and streams results out.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_host_ctrl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int REQ_CYC = 2,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_count,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_count,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_req,
    input  logic          cpu_done,
    output logic          busy,
    output logic          timeout_err,
    output logic [CW-1:0] run_cycles
);

    localparam int RW = (REQ_CYC < 2) ? 1 : $clog2(REQ_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] ld_base_q, ld_base_d, ld_count_q, ld_count_d;
    logic [AW-1:0] rd_base_q, rd_base_d, rd_count_q, rd_count_d;
    logic [RW-1:0] req_cnt_q, req_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          armed_q, armed_d;
    logic          timeout_err_q, timeout_err_d;
    logic [CW-1:0] run_cycles_q, run_cycles_d;

    // Outputs decode only from registered state/index, never from start/cpu_done.
    assign ld_ready    = (state_q == S_LOAD);
    assign mem_wr_en   = (state_q == S_LOAD) && ld_valid;
    assign mem_wdata   = (state_q == S_LOAD) ? ld_data : '0;
    assign mem_addr    = (state_q == S_LOAD) ? AW'(ld_base_q + idx_q) :
                         (state_q == S_READ) ? AW'(rd_base_q + idx_q) : '0;
    assign out_valid   = (state_q == S_READ);
    assign out_data    = (state_q == S_READ) ? mem_rdata : '0;
    assign cpu_req     = (state_q == S_REQ);
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;
    assign run_cycles  = run_cycles_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ld_base_d     = ld_base_q;
        ld_count_d    = ld_count_q;
        rd_base_d     = rd_base_q;
        rd_count_d    = rd_count_q;
        req_cnt_d     = req_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        armed_d       = armed_q;
        timeout_err_d = timeout_err_q;
        run_cycles_d  = run_cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ld_base_d     = ld_base;
                    ld_count_d    = ld_count;
                    rd_base_d     = rd_base;
                    rd_count_d    = rd_count;
                    idx_d         = '0;
                    req_cnt_d     = '0;
                    timeout_err_d = 1'b0;
                    run_cycles_d  = '0;
                    state_d       = (ld_count != '0) ? S_LOAD : S_REQ;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    if (idx_q == AW'(ld_count_q - AW'(1))) begin
                        idx_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_REQ: begin
                if (req_cnt_q == RW'(REQ_CYC - 1)) begin
                    req_cnt_d  = '0;
                    wait_cnt_d = '0;
                    armed_d    = 1'b0;
                    state_d    = S_WAIT;
                end else begin
                    req_cnt_d = req_cnt_q + RW'(1);
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + TW'(1);
                if (run_cycles_q != {CW{1'b1}}) begin
                    run_cycles_d = run_cycles_q + CW'(1);
                end
                if (!cpu_done) begin
                    armed_d = 1'b1;
                end
                // A done that was already high on entry must drop before it counts.
                if (armed_q && cpu_done) begin
                    idx_d   = '0;
                    state_d = (rd_count_q != '0) ? S_READ : S_IDLE;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_READ: begin
                if (out_ready) begin
                    if (idx_q == AW'(rd_count_q - AW'(1))) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            ld_base_q     <= '0;
            ld_count_q    <= '0;
            rd_base_q     <= '0;
            rd_count_q    <= '0;
            req_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            armed_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            run_cycles_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ld_base_q     <= ld_base_d;
            ld_count_q    <= ld_count_d;
            rd_base_q     <= rd_base_d;
            rd_count_q    <= rd_count_d;
            req_cnt_q     <= req_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            armed_q       <= armed_d;
            timeout_err_q <= timeout_err_d;
            run_cycles_q  <= run_cycles_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu_host_ctrl
// Description : Directed self-checking bench for cpu_host_ctrl (TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_host_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ld_base, ld_count, rd_base, rd_count, ld_data;
    logic       ld_valid, ld_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_wr_en, cpu_req, cpu_done, busy, timeout_err;
    logic [15:0] run_cycles;

    logic [7:0] mem [256];
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_host_ctrl #(
        .AW(8), .DW(8), .REQ_CYC(2), .TIMEOUT(16), .CW(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_base(ld_base), .ld_count(ld_count),
        .rd_base(rd_base), .rd_count(rd_count),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .cpu_req(cpu_req), .cpu_done(cpu_done),
        .busy(busy), .timeout_err(timeout_err), .run_cycles(run_cycles)
    );

    // Data memory model with a backdoor write port for preloading results.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_rd [3];
        bit         rdy_pat [12];
        int         k;
        exp_rd  = '{8'h11, 8'h22, 8'h33};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        reset = 1'b0; start = 1'b0; ld_base = '0; ld_count = '0; rd_base = '0;
        rd_count = '0; ld_data = '0; ld_valid = 1'b0; out_ready = 1'b0;
        cpu_done = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cpu_req", cpu_req, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_run_cycles", run_cycles, 0);

        bd_we = 1'b1; bd_addr = 8'h20; bd_data = 8'h5A; step();
        bd_addr = 8'h21; bd_data = 8'hC3; step();
        bd_we = 1'b0;
        reset = 1'b1;
        step();

        // Job 1: four-word preload, stale done, 3-cycle low, two-word readback
        ld_base = 8'h10; ld_count = 8'd4; rd_base = 8'h20; rd_count = 8'd2;
        cpu_done = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("j1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            ld_data = 8'hA1 + 8'(i); ld_valid = 1'b1;
            #1;
            chk("j1_ld_ready", ld_ready, 1);
            chk("j1_wr_en", mem_wr_en, 1);
            chk("j1_wr_addr", mem_addr, 32'h10 + i);
            chk("j1_wr_data", mem_wdata, 32'hA1 + i);
            step();
        end
        ld_valid = 1'b0;
        #1;
        chk("j1_req_c1", cpu_req, 1);
        chk("j1_req_addr", mem_addr, 0);
        chk("j1_req_wr_en", mem_wr_en, 0);
        step();
        chk("j1_req_c2", cpu_req, 1);
        step();
        chk("j1_req_len", cpu_req, 0);
        chk("j1_wait_busy", busy, 1);
        for (int i = 0; i < 4; i++) chk("j1_mem", mem[8'h10 + 8'(i)], 32'hA1 + i);
        step();
        chk("j1_stale_done", out_valid, 0);
        step();
        cpu_done = 1'b0;
        step(); step(); step();
        cpu_done = 1'b1;
        #1;
        chk("j1_pre_rise", out_valid, 0);
        step();
        chk("j1_run_cycles", run_cycles, 6);
        out_ready = 1'b1;
        #1;
        chk("j1_rd0_valid", out_valid, 1);
        chk("j1_rd0_addr", mem_addr, 32'h20);
        chk("j1_rd0_data", out_data, 32'h5A);
        step();
        chk("j1_rd1_data", out_data, 32'hC3);
        step();
        chk("j1_idle_busy", busy, 0);
        chk("j1_idle_valid", out_valid, 0);
        chk("j1_idle_data", out_data, 0);
        cpu_done = 1'b0; out_ready = 1'b0;

        // Job 2: no preload, done stuck low -> timeout after 16 WAIT cycles
        ld_count = 8'd0; rd_base = 8'h20; rd_count = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("j2_req_c1", cpu_req, 1);
        step();
        chk("j2_req_c2", cpu_req, 1);
        step();
        chk("j2_req_off", cpu_req, 0);
        for (int i = 0; i < 16; i++) begin
            chk("j2_wait_busy", busy, 1);
            chk("j2_wait_no_out", out_valid, 0);
            step();
        end
        chk("j2_to_idle", busy, 0);
        chk("j2_timeout_err", timeout_err, 1);
        chk("j2_run_cycles", run_cycles, 16);
        chk("j2_no_out", out_valid, 0);

        // Job 3: wrapped addresses, ignored start pulses, stalled readback
        ld_base = 8'hFE; ld_count = 8'd3; rd_base = 8'hFE; rd_count = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("j3_err_cleared", timeout_err, 0);
        chk("j3_run_cleared", run_cycles, 0);
        ld_data = 8'h11; ld_valid = 1'b1; start = 1'b1; ld_base = 8'h40; rd_count = 8'd1;
        #1;
        chk("j3_addr0", mem_addr, 32'hFE);
        step();
        start = 1'b0; ld_valid = 1'b0;
        #1;
        chk("j3_stall_wr_en", mem_wr_en, 0);
        chk("j3_stall_addr", mem_addr, 32'hFF);
        step();
        ld_data = 8'h22; ld_valid = 1'b1;
        #1;
        chk("j3_addr1", mem_addr, 32'hFF);
        step();
        ld_data = 8'h33;
        #1;
        chk("j3_addr2_wrap", mem_addr, 32'h00);
        step();
        ld_valid = 1'b0; start = 1'b1;
        #1;
        chk("j3_req_c1", cpu_req, 1);
        step();
        start = 1'b0;
        chk("j3_req_c2", cpu_req, 1);
        step();
        chk("j3_wait", cpu_req, 0);
        step();
        cpu_done = 1'b1;
        step();
        chk("j3_run_cycles", run_cycles, 2);
        chk("j3_mem_fe", mem[8'hFE], 32'h11);
        chk("j3_mem_ff", mem[8'hFF], 32'h22);
        chk("j3_mem_00", mem[8'h00], 32'h33);
        k = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            out_ready = rdy_pat[c];
            #1;
            chk("j3_rd_valid", out_valid, 1);
            chk("j3_rd_data", out_data, exp_rd[k]);
            if (rdy_pat[c]) k++;
            step();
        end
        chk("j3_rd_words", k, 3);
        chk("j3_idle", busy, 0);
        cpu_done = 1'b0; out_ready = 1'b0;

        // Reset mid-LOAD
        ld_base = 8'h10; ld_count = 8'd2; rd_count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("r1_in_load", ld_ready, 1);
        #2 reset = 1'b0;
        #1;
        chk("r1_ld_ready", ld_ready, 0);
        chk("r1_busy", busy, 0);
        chk("r1_mem_addr", mem_addr, 0);
        chk("r1_cpu_req", cpu_req, 0);
        reset = 1'b1;
        step();
        chk("r1_stays_idle", busy, 0);

        // Reset mid-REQ
        ld_count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("r2_in_req", cpu_req, 1);
        reset = 1'b0;
        #1;
        chk("r2_req_drop", cpu_req, 0);
        chk("r2_busy", busy, 0);
        reset = 1'b1;
        step();
        chk("r2_no_req", cpu_req, 0);
        chk("r2_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_host_ctrl.md
Name: cpu_host_ctrl

Overview:
Host-side initiator for the CPU core's req/done handshake and its 8-bit data memory. It preloads a block of operands into data memory and asserts req. It then waits for done, with a timeout, and streams a block of result words back out over a valid/ready port. It sits between the test or system harness and the CPU top level. It drives req and owns the data-memory port while the CPU is idle.

Parameters:
AW, 8, data-memory address width
DW, 8, data-memory word width
REQ_CYC, 2, cycles cpu_req is held high per run (>=1)
TIMEOUT, 4096, max cycles spent in WAIT before error
CW, 16, width of run_cycles counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a job; sampled only in IDLE
ld_base  in  AW  first data-memory address for preload
ld_count  in  AW  number of preload words (0 = none)
rd_base  in  AW  first data-memory address for readback
rd_count  in  AW  number of result words (0 = none)
ld_data  in  DW  preload word
ld_valid  in  1  preload word present
ld_ready  out  1  host accepts preload word
out_data  out  DW  result word
out_valid  out  1  result word present
out_ready  in  1  downstream accepts result word
mem_addr  out  AW  data-memory address
mem_wdata  out  DW  data-memory write data
mem_wr_en  out  1  data-memory write strobe
mem_rdata  in  DW  data-memory read data, combinational from mem_addr
cpu_req  out  1  request to CPU
cpu_done  in  1  CPU done (level)
busy  out  1  state != IDLE
timeout_err  out  1  sticky: last job timed out
run_cycles  out  CW  cycles spent in WAIT for last job (saturating)

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, all latched job fields 0, cpu_req=0, ld_ready=0, out_valid=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, out_data=0, busy=0, timeout_err=0, run_cycles=0. Reset mid-job aborts immediately. There is no partial readback and no req glitch.
- States: IDLE, LOAD, REQ, WAIT, READ. All outputs decode from registered state/idx; there are no combinational paths from cpu_done or start.
- IDLE: start=1 latches ld_base, ld_count, rd_base, rd_count, clears idx, timeout_err and run_cycles. Next state is LOAD if ld_count!=0, else REQ. start in any other state is ignored.
- LOAD: ld_ready=1, mem_addr=ld_base+idx (mod 2^AW), mem_wdata=ld_data, mem_wr_en=ld_valid.
  - On ld_valid&ld_ready: idx++.
  - On the transfer with idx==ld_count-1: idx<=0, go REQ.
  - ld_valid=0 stalls indefinitely; there is no timeout in LOAD.
- REQ: cpu_req=1 for exactly REQ_CYC cycles (counter), then WAIT. mem_wr_en=0 and mem_addr=0 from REQ onward until READ.
- WAIT: armed flag is cleared on entry. cpu_done=0 sets armed. cpu_done=1 while armed completes the run.
  - A stale done that stays high is ignored until it has been seen low.
  - run_cycles increments every WAIT cycle and saturates at 2^CW-1.
  - Completion: go READ if rd_count!=0, else IDLE.
  - Timeout: if the WAIT cycle count reaches TIMEOUT without completion, timeout_err<=1, go IDLE, no readback.
  - Completion and timeout in the same cycle: completion wins.
- READ: mem_addr=rd_base+idx (mod 2^AW), out_data=mem_rdata, out_valid=1.
  - On out_valid&out_ready: idx++.
  - The transfer at idx==rd_count-1 returns to IDLE.
  - out_data is stable while out_valid&!out_ready.
  - out_data=0 outside READ.
- Address wrap: base+idx wraps modulo 2^AW (e.g. base 0xFE, count 3 -> 0xFE, 0xFF, 0x00).
- Latency: start at cycle 0 puts LOAD (or REQ) at cycle 1. With ld_count=0, cpu_req is high on cycles 1..REQ_CYC.

Test Plan:
- ld_base=0x10, ld_count=4, data 0xA1..0xA4 back-to-back -> writes to 0x10..0x13 on 4 consecutive cycles. cpu_req is high for exactly 2 cycles, then WAIT.
- cpu_done held 1 throughout REQ, drops for 3 cycles, rises; rd_base=0x20, rd_count=2, memory 0x20=0x5A, 0x21=0xC3 -> completes only on the rise. out stream is 0x5A then 0xC3, then IDLE with busy=0.
- cpu_done stuck 0, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, no out_valid, IDLE. A following start clears timeout_err.
- READ with out_ready toggling 1,0,0,1,... -> out_data is held constant during stalls, with no dropped or duplicated words. ld_base=0xFE, ld_count=3 -> addresses 0xFE, 0xFF, 0x00.
- reset asserted mid-LOAD and mid-REQ -> all outputs 0 immediately, cpu_req never reaches REQ_CYC cycles. start pulses while busy are ignored, with latched fields unchanged.
